card_shoe: RTL and testbench

- Responder end of the card-draw interface. The game controller raises a draw request; this block returns one card drawn without replacement from a finite shoe of NUM_DECKS standard decks.
- Replaces the free-running counter card source, which has unlimited supply and no handshake.
- Keeps a per-rank count of remaining cards and picks ranks with an 8-bit LFSR.
- Uses a four-phase req/ack handshake with the controller and supports reshuffle on command.

---
 rtl/card_shoe.sv | 108 ++++++++++
 tb/tb_card_shoe.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// card_shoe: draws cards without replacement from NUM_DECKS decks over a four-phase req/ack handshake.
// Define CARD_SHOE_FORCE_EN to add force_en/force_rank candidate override.
module card_shoe #(
    parameter int         NUM_DECKS = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_req,
    input  logic       shuffle,
`ifdef CARD_SHOE_FORCE_EN
    input  logic       force_en,
    input  logic [3:0] force_rank,
`endif
    output logic       card_ack,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic       shoe_empty,
    output logic [8:0] cards_left,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SHUF, PICK, PROBE, ACK} state_t;

    localparam logic [5:0] FULL  = 6'(4 * NUM_DECKS);
    localparam logic [8:0] TOTAL = 9'(52 * NUM_DECKS);

    state_t     state;
    logic [7:0] lfsr;
    logic [5:0] count [16];
    logic [3:0] cand, lfsr_rank, pick_rank, next_cand, cand_value;

    assign lfsr_rank  = lfsr[3:0] == 4'd0  ? 4'd13 :
                        lfsr[3:0] == 4'd14 ? 4'd1  :
                        lfsr[3:0] == 4'd15 ? 4'd2  : lfsr[3:0];
`ifdef CARD_SHOE_FORCE_EN
    assign pick_rank  = (force_en && force_rank >= 4'd1 && force_rank <= 4'd13) ? force_rank : lfsr_rank;
`else
    assign pick_rank  = lfsr_rank;
`endif
    assign next_cand  = cand == 4'd13 ? 4'd1 : cand + 4'd1;
    assign cand_value = cand > 4'd10 ? 4'd10 : cand;

    always_ff @(posedge clk) begin
        lfsr <= reset ? LFSR_SEED : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (reset) begin
            state      <= IDLE;
            for (int i = 0; i < 16; i++) count[i] <= FULL;
            cards_left <= TOTAL;
            card_ack   <= 1'b0;
            card_rank  <= 4'd0;
            card_value <= 4'd0;
            shoe_empty <= 1'b0;
            busy       <= 1'b0;
            cand       <= 4'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (shuffle) begin
                        state <= SHUF;
                        busy  <= 1'b1;
                    end else if (draw_req && cards_left == 9'd0) begin
                        state      <= ACK;
                        busy       <= 1'b1;
                        card_ack   <= 1'b1;
                        shoe_empty <= 1'b1;
                        card_rank  <= 4'd0;
                        card_value <= 4'd0;
                    end else if (draw_req) begin
                        state <= PICK;
                        busy  <= 1'b1;
                    end
                end
                SHUF: begin
                    for (int i = 0; i < 16; i++) count[i] <= FULL;
                    cards_left <= TOTAL;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                PICK: begin
                    cand  <= pick_rank;
                    state <= PROBE;
                end
                PROBE: begin
                    // cards_left > 0 guarantees a hit within 13 probes
                    if (count[cand] != 6'd0) begin
                        count[cand] <= count[cand] - 6'd1;
                        cards_left  <= cards_left - 9'd1;
                        card_rank   <= cand;
                        card_value  <= cand_value;
                        shoe_empty  <= 1'b0;
                        card_ack    <= 1'b1;
                        state       <= ACK;
                    end else begin
                        cand <= next_cand;
                    end
                end
                ACK: begin
                    if (!draw_req) begin
                        card_ack <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: randomized draws checked against a per-rank count model of the shoe.
module tb_card_shoe;
    localparam int         ND    = 1;
    localparam int         TOTAL = 52 * ND;
    localparam logic [7:0] SEED  = 8'hA5;

    logic       clk = 1'b0;
    logic       reset, draw_req, shuffle;
    logic       card_ack, shoe_empty, busy;
    logic [3:0] card_rank, card_value;
    logic [8:0] cards_left;

    int checks = 0;
    int errors = 0;
    int cnt [14];
    int left;
    logic [7:0] lm;

    card_shoe #(.NUM_DECKS(ND), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .draw_req(draw_req), .shuffle(shuffle),
`ifdef CARD_SHOE_FORCE_EN
        .force_en(1'b0), .force_rank(4'd0),
`endif
        .card_ack(card_ack), .card_rank(card_rank), .card_value(card_value),
        .shoe_empty(shoe_empty), .cards_left(cards_left), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR: value held by the shoe's generator during each cycle
    always @(posedge clk) lm <= reset ? SEED : {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic refill();
        for (int r = 1; r <= 13; r++) cnt[r] = 4 * ND;
        left = TOTAL;
    endtask

    task automatic draw(input bit sh, input int hold);
        int pre, edges, cand, skips, exp_lat, er, lows, nn;
        bit was_empty;
        pre = sh ? 2 : 0;
        @(posedge clk); #1;
        draw_req = 1'b1;
        shuffle  = sh;
        if (sh) refill();
        was_empty = (left == 0);
        er = 0;
        exp_lat = was_empty ? 1 : 0;
        edges = 0;
        while (card_ack !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1 && sh) begin
                chk("shuf_busy", busy, 1);
                shuffle = 1'b0;
            end
            if (edges == pre + 1 && !was_empty) begin
                nn = int'(lm[3:0]);
                cand = nn == 0 ? 13 : nn == 14 ? 1 : nn == 15 ? 2 : nn;
                skips = 0;
                while (cnt[cand] == 0 && skips < 13) begin
                    cand = cand == 13 ? 1 : cand + 1;
                    skips++;
                end
                er = cand;
                exp_lat = pre + 3 + skips;
            end
        end
        chk("ack", card_ack, 1);
        chk("latency", edges, exp_lat);
        chk("rank", card_rank, er);
        chk("value", card_value, er > 10 ? 10 : er);
        chk("empty", shoe_empty, was_empty);
        if (!was_empty) begin
            cnt[er]--;
            left--;
        end
        chk("left", cards_left, left);
        lows = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (card_ack !== 1'b1) lows++;
        end
        chk("ack_hold", lows, 0);
        chk("left_hold", cards_left, left);
        draw_req = 1'b0;
        @(posedge clk); #1;
        chk("ack_drop", card_ack, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic shuffle_pulse();
        @(posedge clk); #1;
        shuffle = 1'b1;
        @(posedge clk); #1;
        chk("shuf_busy", busy, 1);
        shuffle = 1'b0;
        @(posedge clk); #1;
        refill();
        chk("shuf_left", cards_left, TOTAL);
        chk("shuf_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        draw_req = 1'b0;
        shuffle = 1'b0;
        refill();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ack", card_ack, 0);
        chk("rst_rank", card_rank, 0);
        chk("rst_value", card_value, 0);
        chk("rst_empty", shoe_empty, 0);
        chk("rst_left", cards_left, TOTAL);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 20; i++) draw($urandom_range(0, 4) == 0, $urandom_range(0, 6));
        shuffle_pulse();

        for (int i = 0; i < TOTAL; i++) draw(1'b0, $urandom_range(0, 3));
        draw(1'b0, 2);
        shuffle_pulse();
        draw(1'b0, 1);

        @(posedge clk); #1;
        draw_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        draw_req = 1'b0;
        refill();
        chk("prst_ack", card_ack, 0);
        chk("prst_busy", busy, 0);
        chk("prst_left", cards_left, TOTAL);
        chk("prst_lfsr_model", lm, SEED);
        draw(1'b0, 0);
        draw(1'b1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
